// File: rtl/fir_pkg.sv
// Shared types and constants for the serial FIR sequencer.
package fir_pkg;

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

  localparam int N_TAPS_DEF = 4;

  // Tap-index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TAP_IW = idx_w(N_TAPS_DEF);

  function automatic int coef_default(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient-config and result signals of the FIR sequencer.
interface fir_mac_sequencer_if
  import fir_pkg::*;
#(
  parameter int N_TAPS = 4,
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int AW     = 16
);
  localparam int IW = idx_w(N_TAPS);

  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 cfg_we;
  logic [IW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 cfg_err;
  logic                 m_valid;
  logic signed [AW-1:0] m_data;
  logic                 busy;

  modport master (
    output s_valid, s_data, cfg_we, cfg_addr, cfg_data,
    input  s_ready, cfg_err, m_valid, m_data, busy
  );

  modport slave (
    input  s_valid, s_data, cfg_we, cfg_addr, cfg_data,
    output s_ready, cfg_err, m_valid, m_data, busy
  );
endinterface

// File: rtl/fir_mac_unit.sv
// Combinational signed multiply-accumulate: o_sum = i_acc + sext(i_x * i_c), wrapping at AW bits.
module fir_mac_unit #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 16
) (
  input  logic signed [AW-1:0] i_acc,
  input  logic signed [DW-1:0] i_x,
  input  logic signed [CW-1:0] i_c,
  output logic signed [AW-1:0] o_sum
);
  logic signed [DW+CW-1:0] w_prod;

  assign w_prod = i_x * i_c;
  assign o_sum  = i_acc + AW'(w_prod);
endmodule

// File: rtl/fir_mac_sequencer.sv
// Serial FIR controller: one shared MAC walks N_TAPS taps per accepted sample.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS = 4,
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int AW     = 16
) (
  input logic                  clk,
  input logic                  reset,
  fir_mac_sequencer_if.slave   bus
);
  localparam int             IW   = idx_w(N_TAPS);
  localparam logic [IW:0]    NT   = (IW+1)'(N_TAPS);
  localparam logic [IW-1:0]  LAST = IW'(N_TAPS - 1);

  state_t                     r_state;
  logic [IW-1:0]              r_k;
  logic signed [AW-1:0]       r_acc;
  logic [N_TAPS-1:0][DW-1:0]  r_dl;
  logic [N_TAPS-1:0][CW-1:0]  r_coef;
  logic                       r_m_valid;
  logic signed [AW-1:0]       r_m_data;
  logic                       r_cfg_err;

  logic                       w_s_ready;
  logic                       w_addr_ok;
  logic signed [AW-1:0]       w_sum;

  // cfg_we steals the IDLE slot so a write and an accept never share an edge.
  assign w_s_ready = (r_state == IDLE) && !bus.cfg_we && !reset;
  assign w_addr_ok = {1'b0, bus.cfg_addr} < NT;

  fir_mac_unit #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
    .i_acc (r_acc),
    .i_x   (r_dl[r_k]),
    .i_c   (r_coef[r_k]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_acc     <= '0;
      r_dl      <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_cfg_err <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) r_coef[k] <= CW'(coef_default(k));
    end else begin
      r_m_valid <= 1'b0;
      r_cfg_err <= 1'b0;
      if (bus.cfg_we) begin
        if (r_state == IDLE && w_addr_ok) r_coef[bus.cfg_addr] <= bus.cfg_data;
        else                              r_cfg_err <= 1'b1;
      end
      case (r_state)
        IDLE: if (bus.s_valid && w_s_ready) begin
          r_dl    <= {r_dl[N_TAPS-2:0], bus.s_data};
          r_acc   <= '0;
          r_k     <= '0;
          r_state <= MAC;
        end
        MAC: begin
          r_acc <= w_sum;
          if (r_k == LAST) begin
            r_m_data  <= w_sum;
            r_m_valid <= 1'b1;
            r_k       <= '0;
            r_state   <= IDLE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.cfg_err = r_cfg_err;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.busy    = (r_state == MAC);
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed + random bench for fir_mac_sequencer against a dot-product reference model.
module tb_fir_mac_sequencer;
  localparam int N = 4, DW = 8, CW = 8, AW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic signed [DW-1:0] hist [N];
  int                   coef [N];
  time                  t_acc, t_prev;
  int                   last_wait;

  fir_mac_sequencer_if #(.N_TAPS(N), .DW(DW), .CW(CW), .AW(AW)) bus ();
  fir_mac_sequencer #(.N_TAPS(N), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin hist[k] = '0; coef[k] = k + 1; end
  endfunction

  function automatic void model_push(input logic signed [DW-1:0] x);
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endfunction

  function automatic logic signed [AW-1:0] model_out();
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(hist[k]) * longint'(coef[k]);
    return AW'(s);
  endfunction

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data",  bus.m_data,  0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int a, input logic [CW-1:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'(a); bus.cfg_data = d;
    #1 chk("wr_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    chk("wr_cfg_err", bus.cfg_err, 0);
    coef[a] = int'($signed(d));
  endtask

  // Offer x until accepted, then check the result, latency and ready-low span.
  task automatic send(input logic signed [DW-1:0] x, input bit inj, input string tag);
    int n, e, rl;
    bus.s_valid = 1'b1; bus.s_data = x; n = 0;
    #0;
    while (bus.s_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk($sformatf("%s_accept_timeout", tag), n < 40, 1);
    last_wait = n;
    @(posedge clk); t_acc = $time; #1;
    bus.s_valid = 1'b0;
    model_push(x);
    chk($sformatf("%s_busy", tag), bus.busy, 1);
    chk($sformatf("%s_mv_gap", tag), bus.m_valid, 0);
    rl = (bus.s_ready === 1'b0) ? 1 : 0;
    e = 0;
    if (inj) begin bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_data = 8'sd7; end
    while (bus.m_valid !== 1'b1 && e < 20) begin
      @(posedge clk); #1; e++;
      if (inj && e == 1) begin bus.cfg_we = 1'b0; chk($sformatf("%s_cfg_err", tag), bus.cfg_err, 1); end
      if (inj && e == 2) chk($sformatf("%s_cfg_err_end", tag), bus.cfg_err, 0);
      if (bus.m_valid !== 1'b1 && bus.s_ready !== 1'b1) rl++;
    end
    chk($sformatf("%s_latency", tag), e, N);
    chk($sformatf("%s_ready_low", tag), rl, N);
    chk($sformatf("%s_m_data", tag), bus.m_data, model_out());
    chk($sformatf("%s_ready_back", tag), bus.s_ready, 1);
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    model_reset();

    // Default coefficients: expect 10,40,100,200,250.
    do_reset();
    send(8'sd10, 1'b0, "def0"); chk("def0_val", bus.m_data, 10);
    send(8'sd20, 1'b0, "def1"); chk("def1_val", bus.m_data, 40);
    send(8'sd30, 1'b0, "def2"); chk("def2_val", bus.m_data, 100);
    send(8'sd40, 1'b0, "def3"); chk("def3_val", bus.m_data, 200);
    send(8'sd0,  1'b0, "def4"); chk("def4_val", bus.m_data, 250);
    @(posedge clk); #1 chk("def_mv_single", bus.m_valid, 0);
    chk("def_hold", bus.m_data, 250);

    // Write collides with a sample: write wins, sample goes next cycle.
    do_reset();
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = -8'sd128;
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = -8'sd1;
    #1 chk("coll_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    chk("coll_not_busy", bus.busy, 0);
    coef[0] = -1;
    send(-8'sd128, 1'b0, "coll");
    chk("coll_wait", last_wait, 0);
    chk("coll_val", bus.m_data, 128);

    // Write during MAC is rejected; coef[2] stays 3.
    do_reset();
    send(8'sd10, 1'b1, "rej0"); chk("rej0_val", bus.m_data, 10);
    send(8'sd0,  1'b0, "rej1"); chk("rej1_val", bus.m_data, 20);
    send(8'sd0,  1'b0, "rej2"); chk("rej2_val", bus.m_data, 30);

    // Wrap-around modulo 2^16.
    do_reset();
    for (int a = 0; a < N; a++) write_coef(a, 8'h80);
    send(-8'sd128, 1'b0, "wrap0"); chk("wrap0_val", bus.m_data, 16384);
    send(-8'sd128, 1'b0, "wrap1"); chk("wrap1_val", bus.m_data, -32768);
    send(-8'sd128, 1'b0, "wrap2"); chk("wrap2_val", bus.m_data, -16384);
    send(-8'sd128, 1'b0, "wrap3"); chk("wrap3_val", bus.m_data, 0);

    // Reset two cycles into MAC aborts and restores defaults.
    do_reset();
    write_coef(0, 8'sd5);
    bus.s_valid = 1'b1; bus.s_data = 8'sd7;
    #1 chk("rmid_ready", bus.s_ready, 1);
    @(posedge clk); #1 bus.s_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmid_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rmid_m_valid", bus.m_valid, 0);
    chk("rmid_m_data",  bus.m_data,  0);
    chk("rmid_s_ready", bus.s_ready, 0);
    chk("rmid_busy0",   bus.busy,    0);
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1 chk("rmid_no_mv", bus.m_valid, 0); end
    #2 reset = 1'b0;
    model_reset();
    #1 chk("rmid_ready_back", bus.s_ready, 1);
    send(8'sd10, 1'b0, "rmid"); chk("rmid_val", bus.m_data, 10);

    // Back-to-back: one accept every N+1 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'sd5, 1'b0, $sformatf("b2b%0d", i));
      if (i > 0) begin
        chk($sformatf("b2b%0d_period", i), longint'(t_acc - t_prev), 50);
        chk($sformatf("b2b%0d_wait", i), last_wait, 0);
      end
      t_prev = t_acc;
    end
    chk("b2b_last", bus.m_data, 50);

    // Random samples interleaved with random coefficient writes.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) write_coef($urandom_range(0, N - 1), 8'($urandom));
      send(8'($urandom), 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Serial FIR engine controller. It time-multiplexes one signed multiply-accumulate unit across N_TAPS taps, so the filter costs one multiplier instead of N_TAPS.
- Sequences the tap delay line and MAC for each input sample.
- Owns a runtime-writable coefficient bank.
- Sits between the sample source (valid/ready) and the downstream consumer (valid pulse).

Parameters:
N_TAPS, 4, number of filter taps (>=2)
DW, 8, signed input sample width
CW, 8, signed coefficient width
AW, 16, signed accumulator/output width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  sequencer can accept a sample
s_data  in  DW  signed input sample
cfg_we  in  1  coefficient write strobe
cfg_addr  in  clog2(N_TAPS)  coefficient index
cfg_data  in  CW  signed coefficient value
cfg_err  out  1  one-cycle pulse: write rejected
m_valid  out  1  one-cycle pulse: m_data holds a new result
m_data  out  AW  signed filter output
busy  out  1  high while in MAC state

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; m_valid=0, m_data=0, cfg_err=0, busy=0.
  - Delay line all 0; acc=0; tap index=0.
  - Coefficients restore to defaults coef[k]=k+1 (1,2,3,4 for N_TAPS=4).
- States:
  - IDLE: waits for a sample or coefficient write.
  - MAC: one tap per cycle.
- s_ready = (state==IDLE) && !cfg_we. It is combinational and 0 during reset.
- Accept (IDLE, s_valid && s_ready), at edge E0:
  - Delay line shifts: dl[k] <= dl[k-1]; dl[0] <= s_data.
  - acc <= 0, k <= 0, state -> MAC.
- MAC, edges E1..E_N_TAPS: acc <= acc + dl[k]*coef[k], k increments.
  - Product is DW+CW bits signed, sign-extended to AW.
  - Accumulation wraps modulo 2^AW; no saturation.
- Last MAC edge (k==N_TAPS-1):
  - m_data <= acc + dl[k]*coef[k]; m_valid <= 1 for exactly one cycle; state -> IDLE.
  - Latency: m_valid is high in the cycle after E_N_TAPS, i.e. N_TAPS cycles after the accept edge.
- m_data holds its value until the next result. m_valid is never high in consecutive cycles.
- Next sample may be accepted in the same cycle m_valid is high. Max throughput: one sample per N_TAPS+1 cycles.
- Coefficient write:
  - In IDLE, cfg_we=1 writes coef[cfg_addr] <= cfg_data at the clock edge.
  - cfg_we has priority over s_valid: the sample is held off via s_ready=0 and accepted in a later cycle.
  - New coefficients apply to the next accepted sample.
- cfg_we in MAC state: write ignored, coefficients unchanged, cfg_err=1 in the following cycle.
- cfg_addr >= N_TAPS (non-power-of-2 N_TAPS): write ignored, cfg_err pulses.
- s_valid while not ready: no state change; the source must hold s_data stable until accepted.
- Reset mid-MAC: computation aborted, no m_valid, all state as in reset (coefficients back to defaults).

Decomposition:
- Package fir_pkg:
  - state enum (IDLE, MAC);
  - default coefficient function/constant (k+1);
  - localparam for tap-index width clog2(N_TAPS).
- Sub-module fir_mac_unit: combinational signed DW x CW multiply, sign-extend to AW, add to acc input. Keeps the arithmetic width rules in one place.
- Delay line, coefficient bank and FSM stay in fir_mac_sequencer.

Test Plan:
- Default coefficients: after reset, feed 10,20,30,40,0, each at the first ready cycle.
  -> m_data 10,40,100,200,250.
  -> each m_valid exactly 4 cycles after its accept.
  -> s_ready low for 4 cycles per sample.
- Coefficient write with collision: in IDLE, drive cfg_we (addr 0, data -1) and s_valid (s_data -128) in the same cycle.
  -> s_ready=0 that cycle; sample accepted next cycle; m_data=128.
- Rejected write: pulse cfg_we (addr 2, data 7) on the cycle after an accept.
  -> cfg_err high one cycle; m_data unchanged vs defaults; a later sample confirms coef[2]=3.
- Wrap-around: write all coefficients to -128, then feed four samples of -128.
  -> outputs 16384, 32768 wrapped to -32768, -16384, then 0 (65536 mod 2^16).
- Reset mid-operation: assert reset 2 cycles into MAC.
  -> no m_valid; m_data=0; s_ready returns 1 after release; sample 10 gives m_data 10 (delay line and coefficients back to defaults).
- Back-to-back: hold s_valid high with sample 5 continuously.
  -> accepts every 5 cycles; m_valid period 5; outputs 5,15,30,50,50.
